// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU/branch/address ops, two-cycle multiply and
// a 32-step restoring divider, handed to the memory stage via enabled/completed.
module exec_stage #(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enabled,
  input  logic [4:0]  op,
  input  logic        use_imm,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  output logic        completed,
  output logic [4:0]  op_n,
  output logic [31:0] result,
  output logic [31:0] store_data,
  output logic        branch_taken,
  output logic [31:0] branch_target
);

  localparam int CNT_W = $clog2(DIV_STEPS);

  localparam logic [4:0] OP_SUB   = 5'd1,  OP_SLL  = 5'd2,  OP_SLT   = 5'd3,  OP_SLTU  = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5,  OP_SRL  = 5'd6,  OP_SRA   = 5'd7,  OP_OR    = 5'd8;
  localparam logic [4:0] OP_AND   = 5'd9,  OP_MUL  = 5'd10, OP_MULH  = 5'd11, OP_MULHU = 5'd13;
  localparam logic [4:0] OP_DIV   = 5'd14, OP_REM  = 5'd16, OP_REMU  = 5'd17, OP_ADDR  = 5'd18;
  localparam logic [4:0] OP_LUI   = 5'd19, OP_AUIPC = 5'd20, OP_JAL  = 5'd21, OP_JALR  = 5'd22;
  localparam logic [4:0] OP_BEQ   = 5'd23, OP_BNE  = 5'd24, OP_BLT   = 5'd25, OP_BGE   = 5'd26;
  localparam logic [4:0] OP_BLTU  = 5'd27, OP_BGEU = 5'd28;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL_WAIT = 2'd1, DIV_RUN = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               done_q, done_d;
  logic [4:0]         op_n_q, op_n_d;
  logic [31:0]        result_q, result_d;
  logic [31:0]        store_data_q, store_data_d;
  logic               branch_taken_q, branch_taken_d;
  logic [31:0]        branch_target_q, branch_target_d;
  logic [63:0]        prod_q, prod_d;
  logic [31:0]        rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic               q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic               is_mul, is_div, div_signed, div_is_rem, div_fast, last_step;
  logic [31:0]        div_fast_res, dvd_mag, dvs_mag;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] mul_full;
  logic [32:0]        div_trial;
  logic               div_fit;
  logic [31:0]        rem_step, quo_step, q_final, r_final;
  logic [31:0]        alu_b, jalr_sum, exec_result, exec_target;
  logic               exec_taken;

  assign is_mul     = op inside {[OP_MUL:OP_MULHU]};
  assign is_div     = op inside {[OP_DIV:OP_REMU]};
  assign div_signed = (op == OP_DIV) || (op == OP_REM);
  assign div_is_rem = (op == OP_REM) || (op == OP_REMU);
  assign div_fast   = (rs2_val == 32'd0) ||
                      (div_signed && rs1_val == 32'h8000_0000 && rs2_val == 32'hFFFF_FFFF);
  assign div_fast_res = (rs2_val == 32'd0) ? (div_is_rem ? rs1_val : 32'hFFFF_FFFF)
                                           : (div_is_rem ? 32'd0   : 32'h8000_0000);
  assign dvd_mag = (div_signed && rs1_val[31]) ? 32'd0 - rs1_val : rs1_val;
  assign dvs_mag = (div_signed && rs2_val[31]) ? 32'd0 - rs2_val : rs2_val;

  // Low word is sign-agnostic, so only the high-word variants steer operand extension.
  assign mul_a    = {(op != OP_MULHU) && rs1_val[31], rs1_val};
  assign mul_b    = {(op == OP_MULH) && rs2_val[31], rs2_val};
  assign mul_full = 64'(mul_a) * 64'(mul_b);

  // Remainder stays below the divisor, so bit 32 of the trial is a clean borrow flag.
  assign div_trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
  assign div_fit   = ~div_trial[32];
  assign rem_step  = div_fit ? div_trial[31:0] : {rem_q[30:0], quo_q[31]};
  assign quo_step  = {quo_q[30:0], div_fit};
  assign q_final   = q_neg_q ? 32'd0 - quo_step : quo_step;
  assign r_final   = r_neg_q ? 32'd0 - rem_step : rem_step;
  assign last_step = (count_q == CNT_W'(DIV_STEPS - 1));

  always_comb begin
    alu_b       = (use_imm && op != OP_SUB) ? imm : rs2_val;
    jalr_sum    = rs1_val + imm;
    exec_result = '0;
    exec_taken  = 1'b0;
    exec_target = pc + imm;
    case (op)
      OP_SUB:   exec_result = rs1_val - rs2_val;
      OP_SLL:   exec_result = rs1_val << alu_b[4:0];
      OP_SLT:   exec_result = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      OP_SLTU:  exec_result = {31'd0, rs1_val < alu_b};
      OP_XOR:   exec_result = rs1_val ^ alu_b;
      OP_SRL:   exec_result = rs1_val >> alu_b[4:0];
      OP_SRA:   exec_result = $unsigned($signed(rs1_val) >>> alu_b[4:0]);
      OP_OR:    exec_result = rs1_val | alu_b;
      OP_AND:   exec_result = rs1_val & alu_b;
      OP_ADDR:  exec_result = rs1_val + imm;
      OP_LUI:   exec_result = imm;
      OP_AUIPC: exec_result = pc + imm;
      OP_JAL: begin
        exec_result = pc + 32'd4;
        exec_taken  = 1'b1;
      end
      OP_JALR: begin
        exec_result = pc + 32'd4;
        exec_taken  = 1'b1;
        exec_target = {jalr_sum[31:1], 1'b0};
      end
      OP_BEQ:   exec_taken = (rs1_val == rs2_val);
      OP_BNE:   exec_taken = (rs1_val != rs2_val);
      OP_BLT:   exec_taken = ($signed(rs1_val) < $signed(rs2_val));
      OP_BGE:   exec_taken = ($signed(rs1_val) >= $signed(rs2_val));
      OP_BLTU:  exec_taken = (rs1_val < rs2_val);
      OP_BGEU:  exec_taken = (rs1_val >= rs2_val);
      default:  exec_result = rs1_val + alu_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= IDLE;
      count_q         <= '0;
      done_q          <= 1'b0;
      op_n_q          <= '0;
      result_q        <= '0;
      store_data_q    <= '0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
      prod_q          <= '0;
      rem_q           <= '0;
      quo_q           <= '0;
      dvs_q           <= '0;
      q_neg_q         <= 1'b0;
      r_neg_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      done_q          <= done_d;
      op_n_q          <= op_n_d;
      result_q        <= result_d;
      store_data_q    <= store_data_d;
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
      prod_q          <= prod_d;
      rem_q           <= rem_d;
      quo_q           <= quo_d;
      dvs_q           <= dvs_d;
      q_neg_q         <= q_neg_d;
      r_neg_q         <= r_neg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enabled) begin
          if (is_mul)                    state_d = MUL_WAIT;
          else if (is_div && !div_fast)  state_d = DIV_RUN;
        end
      end
      MUL_WAIT: state_d = IDLE;
      DIV_RUN:  if (last_step) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d         = count_q;
    done_d          = done_q;
    op_n_d          = op_n_q;
    result_d        = result_q;
    store_data_d    = store_data_q;
    branch_taken_d  = branch_taken_q;
    branch_target_d = branch_target_q;
    prod_d          = prod_q;
    rem_d           = rem_q;
    quo_d           = quo_q;
    dvs_d           = dvs_q;
    q_neg_d         = q_neg_q;
    r_neg_d         = r_neg_q;
    case (state_q)
      IDLE: begin
        if (enabled) begin
          op_n_d         = op;
          store_data_d   = rs2_val;
          done_d         = 1'b0;
          branch_taken_d = 1'b0;
          if (is_mul) begin
            prod_d = mul_full;
          end else if (is_div) begin
            if (div_fast) begin
              result_d = div_fast_res;
              done_d   = 1'b1;
            end else begin
              quo_d   = dvd_mag;
              rem_d   = '0;
              dvs_d   = dvs_mag;
              q_neg_d = div_signed && (rs1_val[31] ^ rs2_val[31]);
              r_neg_d = div_signed && rs1_val[31];
              count_d = '0;
            end
          end else begin
            result_d        = exec_result;
            branch_taken_d  = exec_taken;
            branch_target_d = exec_target;
            done_d          = 1'b1;
          end
        end
      end
      MUL_WAIT: begin
        result_d = (op_n_q == OP_MUL) ? prod_q[31:0] : prod_q[63:32];
        done_d   = 1'b1;
      end
      DIV_RUN: begin
        rem_d   = rem_step;
        quo_d   = quo_step;
        count_d = count_q + CNT_W'(1);
        if (last_step) begin
          result_d = ((op_n_q == OP_REM) || (op_n_q == OP_REMU)) ? r_final : q_final;
          done_d   = 1'b1;
          count_d  = '0;
        end
      end
      default: ;
    endcase
  end

  assign completed     = done_q & ~enabled;
  assign op_n          = op_n_q;
  assign result        = result_q;
  assign store_data    = store_data_q;
  assign branch_taken  = branch_taken_q;
  assign branch_target = branch_target_q;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: directed ops push hand-computed expectations,
// a negedge monitor pops one entry on each rising completed.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rstn, enabled, use_imm;
  logic [4:0]  op;
  logic [31:0] rs1_val, rs2_val, imm, pc;
  logic        completed, branch_taken;
  logic [4:0]  op_n;
  logic [31:0] result, store_data, branch_target;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] res;
    logic        taken;
    logic        chk_tgt;
    logic [31:0] tgt;
    logic [31:0] sdata;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_miscompares = 0;
  logic comp_prev = 1'b0;

  exec_stage #(.DIV_STEPS(32)) dut (
    .clk(clk), .rstn(rstn), .enabled(enabled), .op(op), .use_imm(use_imm),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
    .completed(completed), .op_n(op_n), .result(result), .store_data(store_data),
    .branch_taken(branch_taken), .branch_target(branch_target)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one start for a single cycle; push the expectation once the start edge has passed.
  task automatic applyStimulus(input string name, input logic [4:0] o, input logic ui,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] i,
                               input logic [31:0] p, input logic [31:0] er, input logic et,
                               input logic ct, input logic [31:0] etg, input int lat, input bit push);
    exp_t e;
    @(posedge clk); #1;
    enabled = 1'b1; op = o; use_imm = ui; rs1_val = a; rs2_val = b; imm = i; pc = p;
    @(posedge clk); #1;
    enabled = 1'b0; op = 5'd0; use_imm = 1'b0;
    rs1_val = 32'hDEAD_BEEF; rs2_val = 32'hCAFE_F00D; imm = 32'h1234_5678; pc = 32'h0BAD_0000;
    if (push) begin
      e.name = name; e.op = o; e.res = er; e.taken = et; e.chk_tgt = ct; e.tgt = etg;
      e.sdata = b; e.lat = lat; e.start = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic waitDone();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_miscompares++;
      $display("[TB] FAIL timeout_%s: got no completion, expected completion", sb[0].name);
      sb.delete();
    end
    #1;
  endtask

  task automatic run(input string name, input logic [4:0] o, input logic ui, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] i, input logic [31:0] p,
                     input logic [31:0] er, input logic et, input logic ct, input logic [31:0] etg,
                     input int lat);
    applyStimulus(name, o, ui, a, b, i, p, er, et, ct, etg, lat, 1'b1);
    waitDone();
  endtask

  // Monitor: a rising completed consumes exactly one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && completed && !comp_prev) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_completion", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_result"}, result, e.res);
        checkOutput({e.name, "_op_n"}, {27'd0, op_n}, {27'd0, e.op});
        checkOutput({e.name, "_store_data"}, store_data, e.sdata);
        checkOutput({e.name, "_taken"}, {31'd0, branch_taken}, {31'd0, e.taken});
        if (e.chk_tgt) checkOutput({e.name, "_target"}, branch_target, e.tgt);
        checkOutput({e.name, "_latency"}, 32'(cyc - e.start + 1), 32'(e.lat));
      end
    end
    comp_prev = rstn ? completed : 1'b0;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic saw;
    rstn = 1'b0; enabled = 1'b0; op = '0; use_imm = 1'b0;
    rs1_val = '0; rs2_val = '0; imm = '0; pc = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_completed", {31'd0, completed}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_op_n", {27'd0, op_n}, 32'd0);
    checkOutput("reset_store_data", store_data, 32'd0);
    checkOutput("reset_taken", {31'd0, branch_taken}, 32'd0);
    checkOutput("reset_target", branch_target, 32'd0);
    rstn = 1'b1;

    run("add_imm_wrap", 5'd0,  1'b1, 32'h7FFF_FFFF, 32'h0000_0055, 32'd1, 32'h40, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 1);
    run("sra",          5'd7,  1'b0, 32'h8000_0000, 32'h0000_0024, 32'd0, 32'h44, 32'hF800_0000, 1'b0, 1'b0, 32'd0, 1);
    run("sub_no_imm",   5'd1,  1'b1, 32'd10, 32'd3, 32'd100, 32'h48, 32'd7, 1'b0, 1'b0, 32'd0, 1);
    run("sll_shamt",    5'd2,  1'b0, 32'd1, 32'h21, 32'd0, 32'h4C, 32'd2, 1'b0, 1'b0, 32'd0, 1);
    run("slt",          5'd3,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h50, 32'd1, 1'b0, 1'b0, 32'd0, 1);
    run("sltu",         5'd4,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h54, 32'd0, 1'b0, 1'b0, 32'd0, 1);
    run("xor_imm",      5'd5,  1'b1, 32'hF0F0_F0F0, 32'd9, 32'h0F0F_0F0F, 32'h58, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 1);
    run("op30_as_add",  5'd30, 1'b0, 32'd5, 32'd6, 32'd0, 32'h5C, 32'd11, 1'b0, 1'b0, 32'd0, 1);
    run("addr",         5'd18, 1'b0, 32'h100, 32'd0, 32'hFFFF_FFFC, 32'h60, 32'hFC, 1'b0, 1'b0, 32'd0, 1);
    run("lui",          5'd19, 1'b0, 32'd0, 32'd0, 32'hABCD_E000, 32'h64, 32'hABCD_E000, 1'b0, 1'b0, 32'd0, 1);
    run("auipc",        5'd20, 1'b0, 32'd0, 32'd0, 32'h2000, 32'h1000, 32'h3000, 1'b0, 1'b0, 32'd0, 1);

    run("mulh",   5'd11, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h70, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 2);
    run("mulhu",  5'd13, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h74, 32'd1, 1'b0, 1'b0, 32'd0, 2);
    run("mul",    5'd10, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h78, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'd0, 2);
    run("mulhsu", 5'd12, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h7C, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 2);

    run("div_neg",      5'd14, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h80, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'd0, 33);
    run("rem_neg",      5'd16, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h84, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 33);
    run("divu",         5'd15, 1'b0, 32'd100, 32'd7, 32'd0, 32'h88, 32'd14, 1'b0, 1'b0, 32'd0, 33);
    run("divu_big",     5'd15, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8C, 32'd0, 1'b0, 1'b0, 32'd0, 33);
    run("divu_by0",     5'd15, 1'b0, 32'd123, 32'd0, 32'd0, 32'h90, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 1);
    run("rem_by0",      5'd16, 1'b0, 32'd5, 32'd0, 32'd0, 32'h94, 32'd5, 1'b0, 1'b0, 32'd0, 1);
    run("div_ovf",      5'd14, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h98, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 1);
    run("rem_ovf",      5'd16, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h9C, 32'd0, 1'b0, 1'b0, 32'd0, 1);

    // A start request while the divider runs must be dropped without disturbing it.
    applyStimulus("remu_busy", 5'd17, 1'b0, 32'd100, 32'd7, 32'd0, 32'hA0, 32'd2, 1'b0, 1'b0, 32'd0, 33, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    enabled = 1'b1; op = 5'd0; rs1_val = 32'd1; rs2_val = 32'd1;
    @(posedge clk); #1;
    enabled = 1'b0;
    waitDone();

    run("blt",  5'd25, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 32'd0, 1'b1, 1'b1, 32'h120, 1);
    run("bltu", 5'd27, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 32'd0, 1'b0, 1'b1, 32'h120, 1);
    run("beq",  5'd23, 1'b0, 32'd5, 32'd5, 32'h40, 32'h180, 32'd0, 1'b1, 1'b1, 32'h1C0, 1);
    run("bge",  5'd26, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h180, 32'd0, 1'b0, 1'b1, 32'h1C0, 1);
    run("jal",  5'd21, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'h300, 32'h304, 1'b1, 1'b1, 32'h2F8, 1);
    run("jalr", 5'd22, 1'b0, 32'h1001, 32'd0, 32'd2, 32'h200, 32'h204, 1'b1, 1'b1, 32'h1002, 1);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("hold_result", result, 32'h204);
    checkOutput("hold_completed", {31'd0, completed}, 32'd1);

    // Reset in the middle of a division: nothing may complete afterwards.
    applyStimulus("div_reset", 5'd14, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hB0, 32'd0, 1'b0, 1'b0, 32'd0, 33, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    checkOutput("midreset_completed", {31'd0, completed}, 32'd0);
    checkOutput("midreset_result", result, 32'd0);
    checkOutput("midreset_op_n", {27'd0, op_n}, 32'd0);
    checkOutput("midreset_store_data", store_data, 32'd0);
    checkOutput("midreset_taken", {31'd0, branch_taken}, 32'd0);
    checkOutput("midreset_target", branch_target, 32'd0);
    rstn = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (completed) saw = 1'b1;
    end
    checkOutput("no_completion_after_reset", {31'd0, saw}, 32'd0);

    run("add_after_reset", 5'd0, 1'b0, 32'd3, 32'd4, 32'd0, 32'hC0, 32'd7, 1'b0, 1'b0, 32'd0, 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage of the multi-cycle core, directly upstream of the memory stage.
- Receives a decoded operation and operand values from decode/register-read.
- Computes ALU, multiply/divide, address, link and branch results.
- Presents result, captured store data and op to the memory stage with a `completed` pulse, using the same enabled/completed handshake as the memory stage.

Parameters:
- DIV_STEPS, 32, number of radix-2 restoring-division iterations (fixed at the data width).

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- enabled  in  1  start pulse; op and operands are valid in this cycle only
- op  in  5  operation code (see Behaviour)
- use_imm  in  1  ALU operand b = imm instead of rs2_val (ops 0-9 only)
- rs1_val  in  32  source operand 1
- rs2_val  in  32  source operand 2 / store data
- imm  in  32  sign-extended immediate
- pc  in  32  PC of the instruction
- completed  out  1  result valid; equals done_reg AND NOT enabled
- op_n  out  5  op captured at start
- result  out  32  computed value (ALU result, address, link address, MUL/DIV result)
- store_data  out  32  rs2_val captured at start
- branch_taken  out  1  redirect required
- branch_target  out  32  redirect PC

Behaviour:
- **Op codes:**
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU
  - 18 ADDR (rs1+imm), 19 LUI (imm), 20 AUIPC (pc+imm)
  - 21 JAL, 22 JALR
  - 23 BEQ, 24 BNE, 25 BLT, 26 BGE, 27 BLTU, 28 BGEU
  - 29-31: treated as ADD (ops 29-31 unused)
- **Shifts:** use operand b[4:0] only. SUB ignores use_imm (always rs2_val).
- **States:** IDLE, MUL_WAIT, DIV_RUN. Start is accepted only in IDLE; `enabled` in any other state is ignored.
- **Start (IDLE && enabled, edge N):**
  - Capture op_n and store_data.
  - Clear done_reg and branch_taken.
- **Single-cycle ops (0-9, 18-28):**
  - result, branch_taken and branch_target are registered at edge N; done_reg=1 at edge N.
  - completed is high from cycle N+1 until the next start.
- **JAL:** result=pc+4; taken=1; target=pc+imm.
- **JALR:** result=pc+4; taken=1; target=(rs1+imm) with bit0 cleared.
- **Branches:** result=0; target=pc+imm; taken per the comparison (signed for BLT/BGE, unsigned for BLTU/BGEU).
- **MUL ops (10-13):**
  - Edge N: registers the 64-bit product and enters MUL_WAIT.
  - Edge N+1: selects the low word (MUL) or high word (others), sets done_reg, returns to IDLE.
  - Signedness: MULH signed×signed; MULHSU signed rs1 × unsigned rs2; MULHU unsigned×unsigned.
- **DIV ops (14-17):**
  - Fast path at edge N (done as single-cycle):
    - divisor==0 → quotient=0xFFFFFFFF, remainder=rs1.
    - signed op with rs1=0x80000000 and rs2=0xFFFFFFFF → quotient=0x80000000, remainder=0.
  - Otherwise at edge N: load |dividend|, |divisor| (magnitudes for signed ops), record quotient and remainder sign flags, count=0, enter DIV_RUN.
  - Each DIV_RUN edge performs one shift-subtract step, count+1.
  - At the edge where count reaches DIV_STEPS-1: apply signs (quotient negative iff operand signs differ; remainder takes the dividend's sign), write result, set done_reg, return to IDLE.
  - Total: completed high from cycle N+33.
- **Arithmetic:** all 32-bit wrap-around; no overflow flags.
- **Reset (rstn=0 at any edge, including mid-MUL/DIV):**
  - state=IDLE, count=0, done_reg=0.
  - op_n=0, result=0, store_data=0, branch_taken=0, branch_target=0.
  - In-flight operation is discarded and no completion is produced.
- **Hold rule:** outputs hold their last values until the next accepted start.
- **Back-to-back starts:** `enabled` in the cycle completed would rise masks completed; the new start is accepted if the state is IDLE.

Test Plan:
- ADD use_imm=1, rs1=0x7FFFFFFF, imm=1 → result=0x80000000; completed high one cycle after start. SRA rs1=0x80000000, rs2=0x24 → 0xF8000000.
- MULH rs1=0xFFFFFFFF(-1), rs2=2 → result=0xFFFFFFFF at N+2. MULHU same operands → 0x00000001. MUL → 0xFFFFFFFE.
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 → 0xFFFFFFFD after exactly 33 cycles. REM same operands → 0xFFFFFFFF. REMU 100/7 → 2. Pulse `enabled` mid-division → ignored, result unchanged.
- DIVU by 0 → 0xFFFFFFFF. REM by 0 with rs1=5 → 5. DIV 0x80000000/-1 → 0x80000000. All three: completed at N+1.
- BLT rs1=-1, rs2=1 → taken=1, target=pc+imm. BLTU same → taken=0. JALR rs1=0x1001, imm=2 → target=0x1002, result=pc+4.
- Assert rstn=0 at DIV_RUN count=10 → all outputs 0, completed never asserts. New ADD start afterwards → completes normally at N+1.
